// File: rtl/pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank -- bank of CHANNELS PWM outputs sharing one period counter.
//
// Duty and period values are written into shadow registers. A commit request
// transfers every shadow into the active set on the next period boundary, so
// an output never shows a period built from a mix of old and new settings.
//
// Parameters
//   WIDTH    counter / duty / period width in bits (2..32)
//   CHANNELS number of PWM outputs (1..16)
//   CHW      channel-select width, >= ceil(log2(CHANNELS)), minimum 1
//
// Ports
//   clk      single clock, all state changes on the rising edge
//   reset    synchronous, active-high reset
//   wr_en    write strobe: wr_duty -> duty shadow[wr_chan]
//   wr_chan  channel index for the duty write (indices >= CHANNELS ignored)
//   wr_duty  duty value for the shadow write
//   per_en   write strobe: per_val -> period shadow
//   per_val  period value (counter runs 0..per_val inclusive)
//   commit   request a shadow->active transfer at the next boundary
//   out      registered PWM outputs, bit i = channel i
//   pending  high while a commit is waiting for a boundary
//   loaded   one-cycle pulse in the cycle after a transfer
// -----------------------------------------------------------------------------
module pwm_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CHW      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CHW-1:0]      wr_chan,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic                per_en,
  input  logic [WIDTH-1:0]    per_val,
  input  logic                commit,
  output logic [CHANNELS-1:0] out,
  output logic                pending,
  output logic                loaded
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] per_sh;
  logic [WIDTH-1:0] per_act;
  logic [WIDTH-1:0] duty_sh  [CHANNELS];
  logic [WIDTH-1:0] duty_act [CHANNELS];

  // Shadow contents as they will be after this edge. The transfer copies
  // these, so a shadow write landing on the transfer edge goes straight
  // through to the active set.
  logic [WIDTH-1:0] per_sh_nxt;
  logic [WIDTH-1:0] duty_sh_nxt [CHANNELS];

  logic boundary;
  logic transfer;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    per_sh_nxt = per_en ? per_val : per_sh;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_sh_nxt[i] = duty_sh[i];
      // A channel index with no matching i simply writes nothing.
      if (wr_en && (wr_chan == CHW'(i))) duty_sh_nxt[i] = wr_duty;
    end
  end

  // With per_act == 0 the counter sits at 0 and every cycle is a boundary.
  assign boundary = (cnt == per_act);
  assign transfer = boundary && (pending || commit);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow and active arrays are small register files with a
      // defined reset value, so they are cleared here rather than left as
      // uninitialised storage.
      cnt     <= '0;
      out     <= '0;
      pending <= 1'b0;
      loaded  <= 1'b0;
      per_sh  <= '1;
      per_act <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      cnt <= boundary ? '0 : cnt + WIDTH'(1);

      // Pre-edge cnt against pre-edge duty: one cycle from cnt to out.
      for (int i = 0; i < CHANNELS; i++) begin
        out[i]     <= (cnt < duty_act[i]);
        duty_sh[i] <= duty_sh_nxt[i];
      end
      per_sh <= per_sh_nxt;

      // A commit arriving on a boundary transfers at once and never shows
      // up on pending; otherwise it is held until the boundary.
      pending <= !transfer && (pending || commit);
      loaded  <= transfer;

      if (transfer) begin
        per_act <= per_sh_nxt;
        for (int i = 0; i < CHANNELS; i++) duty_act[i] <= duty_sh_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_bank -- directed bench for pwm_bank (WIDTH=8, CHANNELS=4, CHW=2) plus
// a CHANNELS=3 instance for out-of-range channel writes. A small model of the
// active settings and the counter phase predicts every output bit.
// -----------------------------------------------------------------------------
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, per_en, commit;
  logic [1:0] wr_chan;
  logic [7:0] wr_duty, per_val;
  logic [3:0] out;
  logic       pending, loaded;

  logic       wr_en3, per_en3, commit3;
  logic [1:0] wr_chan3;
  logic [7:0] wr_duty3, per_val3;
  logic [2:0] out3;
  logic       pending3, loaded3;

  int errors = 0;
  int checks = 0;

  // Model: active settings and the counter value seen before the next edge.
  int phase, per;
  int duty [4];
  int p3, per3;
  int d3 [3];

  always #5 clk = ~clk;

  pwm_bank #(.WIDTH(8), .CHANNELS(4), .CHW(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_duty(wr_duty), .per_en(per_en), .per_val(per_val), .commit(commit),
    .out(out), .pending(pending), .loaded(loaded)
  );

  pwm_bank #(.WIDTH(8), .CHANNELS(3), .CHW(2)) u3 (
    .clk(clk), .reset(reset), .wr_en(wr_en3), .wr_chan(wr_chan3),
    .wr_duty(wr_duty3), .per_en(per_en3), .per_val(per_val3), .commit(commit3),
    .out(out3), .pending(pending3), .loaded(loaded3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    phase = 0; per = 255; p3 = 0; per3 = 255;
    for (int i = 0; i < 4; i++) duty[i] = 0;
    for (int i = 0; i < 3; i++) d3[i] = 0;
  endtask

  task automatic clear_inputs();
    wr_en = 0; wr_chan = 0; wr_duty = 0; per_en = 0; per_val = 0; commit = 0;
    wr_en3 = 0; wr_chan3 = 0; wr_duty3 = 0; per_en3 = 0; per_val3 = 0;
    commit3 = 0;
  endtask

  // One clock with the outputs of both instances checked against the model.
  task automatic tick();
    logic [3:0] e;
    logic [2:0] e3;
    for (int i = 0; i < 4; i++) e[i] = (phase < duty[i]);
    for (int i = 0; i < 3; i++) e3[i] = (p3 < d3[i]);
    @(posedge clk); #1;
    check("out", 32'(out), 32'(e));
    check("out3", 32'(out3), 32'(e3));
    phase = (phase == per) ? 0 : phase + 1;
    p3 = (p3 == per3) ? 0 : p3 + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    check("rst_out", 32'(out), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_loaded", 32'(loaded), 0);
    check("rst_cnt", 32'(dut.cnt), 0);
    check("rst_per_act", 32'(dut.per_act), 255);
    reset = 0;

    // Load shadows on both instances; ch3 write on the 3-channel one is bogus.
    per_en = 1; per_val = 9; wr_en = 1; wr_chan = 0; wr_duty = 3;
    per_en3 = 1; per_val3 = 3; wr_en3 = 1; wr_chan3 = 0; wr_duty3 = 1;
    tick();
    per_en = 0; per_en3 = 0;
    wr_chan = 1; wr_duty = 0;  wr_chan3 = 1; wr_duty3 = 2; tick();
    wr_chan = 2; wr_duty = 10; wr_chan3 = 2; wr_duty3 = 3; tick();
    wr_chan = 3; wr_duty = 5;  wr_chan3 = 3; wr_duty3 = 8'hff; tick();
    wr_en = 0; wr_en3 = 0;
    check("shadow_no_effect", 32'(dut.per_act), 255);
    commit = 1; commit3 = 1; tick();
    commit = 0; commit3 = 0;
    check("pending_set", 32'(pending), 1);
    check("pending3_set", 32'(pending3), 1);
    while (phase != 0) tick();
    check("first_loaded", 32'(loaded), 1);
    check("first_pending_clr", 32'(pending), 0);
    check("u3_loaded", 32'(loaded3), 1);
    check("u3_sh0", 32'(u3.duty_sh[0]), 1);
    check("u3_sh1", 32'(u3.duty_sh[1]), 2);
    check("u3_sh2", 32'(u3.duty_sh[2]), 3);
    duty[0] = 3; duty[1] = 0; duty[2] = 10; duty[3] = 5; per = 9;
    d3[0] = 1; d3[1] = 2; d3[2] = 3; per3 = 3;
    tick();
    check("loaded_one_cycle", 32'(loaded), 0);
    repeat (20) tick();

    // Shadow write without commit leaves the active duty alone.
    while (phase != 4) tick();
    wr_en = 1; wr_chan = 0; wr_duty = 7; tick();
    wr_en = 0;
    check("no_commit_pending", 32'(pending), 0);
    repeat (100) tick();

    // Mid-period commit waits for the 9->0 edge.
    while (phase != 4) tick();
    commit = 1; tick();
    commit = 0;
    check("mid_pending", 32'(pending), 1);
    while (phase != 0) begin
      tick();
      if (phase != 0) check("pending_held", 32'(pending), 1);
    end
    check("mid_loaded", 32'(loaded), 1);
    check("mid_pending_clr", 32'(pending), 0);
    duty[0] = 7;
    repeat (20) tick();

    // Commit plus write exactly on the boundary: write-through, no pending.
    while (phase != 9) tick();
    commit = 1; wr_en = 1; wr_chan = 1; wr_duty = 6; tick();
    commit = 0; wr_en = 0;
    check("bnd_loaded", 32'(loaded), 1);
    check("bnd_pending", 32'(pending), 0);
    duty[1] = 6;
    repeat (20) begin
      tick();
      check("bnd_pending_low", 32'(pending), 0);
    end

    // Period 0: every cycle is a boundary and the counter stays at 0.
    per_en = 1; per_val = 0; wr_en = 1; wr_chan = 0; wr_duty = 1; tick();
    per_en = 0; wr_chan = 1; wr_duty = 0; tick();
    wr_en = 0;
    while (phase != 9) tick();
    commit = 1; tick();
    commit = 0;
    check("p0_loaded", 32'(loaded), 1);
    per = 0; duty[0] = 1; duty[1] = 0;
    repeat (10) begin
      tick();
      check("p0_cnt", 32'(dut.cnt), 0);
    end

    // Back to period 9, then reset with a commit pending mid-period while
    // writes and a commit are also presented.
    per_en = 1; per_val = 9; commit = 1; tick();
    per_en = 0; commit = 0;
    check("p9_loaded", 32'(loaded), 1);
    per = 9;
    while (phase != 4) tick();
    commit = 1; tick();
    commit = 0;
    check("pre_rst_pending", 32'(pending), 1);
    repeat (2) tick();
    reset = 1;
    wr_en = 1; wr_chan = 0; wr_duty = 8'h55; per_en = 1; per_val = 7; commit = 1;
    @(posedge clk); #1;
    clear_inputs();
    reset = 0;
    reset_model();
    check("rst2_out", 32'(out), 0);
    check("rst2_pending", 32'(pending), 0);
    check("rst2_loaded", 32'(loaded), 0);
    check("rst2_cnt", 32'(dut.cnt), 0);
    check("rst2_per_act", 32'(dut.per_act), 255);
    check("rst2_per_sh", 32'(dut.per_sh), 255);
    check("rst2_duty_sh0", 32'(dut.duty_sh[0]), 0);
    check("rst2_duty_act0", 32'(dut.duty_act[0]), 0);
    tick();
    check("rst2_cnt_run", 32'(dut.cnt), 1);
    check("rst2_no_pending", 32'(pending), 0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
